wb_dma_copy: RTL and testbench

WB_DMA_COPY -- requirements
Module: wb_dma_copy

---
 rtl/dma_pkg.sv | 7 +
 rtl/sync_fifo.sv | 39 +++
 rtl/wb_dma_copy.sv | 181 ++++++++++++++++++
 tb/tb_wb_dma_copy.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// dma_pkg: register map, control/status bit positions and FSM encoding shared by the DMA copy engine.
package dma_pkg;
  localparam logic [1:0] REG_SRC = 2'd0, REG_DST = 2'd1, REG_LEN = 2'd2, REG_CTRL = 2'd3;
  localparam int CTRL_START = 0, CTRL_CLR = 1;
  localparam int STAT_BUSY = 0, STAT_DONE = 1, STAT_ERR = 2;
  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead staging FIFO with full/empty flags, occupancy count and flush.
module sync_fifo #(
  parameter int DW = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [DW-1:0]            dat_i,
  output logic [DW-1:0]            dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);
  localparam int PW = $clog2(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [PW:0] wp_q, rp_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else if (flush_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + 1'b1;
      if (pop_i) rp_q <= rp_q + 1'b1;
    end
  always_ff @(posedge clk)
    if (push_i) mem_q[wp_q[PW-1:0]] <= dat_i;
  assign cnt_o = wp_q - rp_q;
  assign full_o = cnt_o == (PW+1)'(DEPTH);
  assign empty_o = wp_q == rp_q;
  assign dat_o = mem_q[rp_q[PW-1:0]];
  assert property (@(posedge clk) disable iff (!rst) !(push_i && full_o));
  assert property (@(posedge clk) disable iff (!rst) !(pop_i && empty_o));
endmodule

// File: rtl/wb_dma_copy.sv
// wb_dma_copy: Wishbone copy engine; CPU programs SRC/DST/LEN, the master alternates
// read bursts into a staging FIFO with write phases that drain it.
module wb_dma_copy
  import dma_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu2d_stb_i,
  input  logic            cpu2d_cyc_i,
  input  logic            cpu2d_we_i,
  input  logic [AW-1:0]   cpu2d_adr_i,
  input  logic [DW-1:0]   cpu2d_dat_i,
  output logic            d2cpu_ack_o,
  output logic [DW-1:0]   d2cpu_dat_o,
  output logic            d2srm_stb_o,
  output logic            d2srm_cyc_o,
  output logic            d2srm_we_o,
  output logic [DW/8-1:0] d2srm_sel_o,
  output logic [AW-1:0]   d2srm_adr_o,
  output logic [DW-1:0]   d2srm_dat_o,
  input  logic            srm2d_ack_i,
  input  logic            srm2d_err_i,
  input  logic [DW-1:0]   srm2d_dat_i,
  output logic            irq_o
);
  localparam int BW = $clog2(BURST + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e state_q, state_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d, len_q, len_d, src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
  logic [AW-3:0] rd_left_q, rd_left_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [DW-1:0] cdat_q, cdat_d, stat, fifo_dat;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, irq_q, irq_d, ack_q, ack_d, req_q, req_d;
  logic acc, push, pop, flush, full, empty, unused_ok;
  logic [CW-1:0] cnt;
  logic [1:0] rsel;

  assign rsel = cpu2d_adr_i[3:2];
  assign unused_ok = ^{cpu2d_adr_i[AW-1:4], cpu2d_adr_i[1:0]};

  sync_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .pop_i(pop), .flush_i(flush), .dat_i(srm2d_dat_i),
    .dat_o(fifo_dat), .full_o(full), .empty_o(empty), .cnt_o(cnt)
  );

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      rd_left_q <= '0;
      burst_q <= '0;
      cdat_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      irq_q <= 1'b0;
      ack_q <= 1'b0;
      req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      rd_left_q <= rd_left_d;
      burst_q <= burst_d;
      cdat_q <= cdat_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      irq_q <= irq_d;
      ack_q <= ack_d;
      req_q <= req_d;
    end

  always_comb begin
    stat = '0;
    stat[STAT_BUSY] = busy_q;
    stat[STAT_DONE] = done_q;
    stat[STAT_ERR] = err_q;
    state_d = state_q;
    src_d = src_q;
    dst_d = dst_q;
    len_d = len_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    rd_left_d = rd_left_q;
    burst_d = burst_q;
    busy_d = busy_q;
    done_d = done_q;
    err_d = err_q;
    irq_d = irq_q;
    req_d = req_q;
    push = 1'b0;
    pop = 1'b0;
    flush = 1'b0;
    // ack_q blocks the access in the ack cycle, so a held strobe never gets back-to-back acks
    acc = cpu2d_stb_i & cpu2d_cyc_i & ~ack_q;
    ack_d = acc;
    cdat_d = !acc ? cdat_q : rsel == REG_SRC ? DW'(src_q) : rsel == REG_DST ? DW'(dst_q) :
             rsel == REG_LEN ? DW'(len_q) : stat;
    if (acc && cpu2d_we_i) begin
      if (!busy_q && rsel == REG_SRC) src_d = AW'(cpu2d_dat_i);
      if (!busy_q && rsel == REG_DST) dst_d = AW'(cpu2d_dat_i);
      if (!busy_q && rsel == REG_LEN) len_d = AW'(cpu2d_dat_i);
      if (rsel == REG_CTRL && cpu2d_dat_i[CTRL_CLR]) begin
        done_d = 1'b0;
        err_d = 1'b0;
        irq_d = 1'b0;
      end
      if (rsel == REG_CTRL && cpu2d_dat_i[CTRL_START] && !busy_q) begin
        busy_d = 1'b1;
        src_ptr_d = src_q;
        dst_ptr_d = dst_q;
        rd_left_d = len_q[AW-1:2];
        burst_d = '0;
        state_d = |len_q[AW-1:2] ? RD : FIN;
      end
    end
    case (state_q)
      RD:
        if (!req_q) req_d = 1'b1;
        else if (srm2d_err_i) begin
          req_d = 1'b0;
          err_d = 1'b1;
          flush = 1'b1;
          state_d = FIN;
        end else if (srm2d_ack_i) begin
          req_d = 1'b0;
          push = ~full;
          src_ptr_d = src_ptr_q + AW'(DW/8);
          rd_left_d = rd_left_q - 1'b1;
          burst_d = burst_q + 1'b1;
          if (burst_d == BW'(BURST) || cnt == CW'(FIFO_DEPTH - 1) || rd_left_d == '0) begin
            burst_d = '0;
            state_d = WR;
          end
        end
      WR:
        if (!req_q) req_d = 1'b1;
        else if (srm2d_err_i) begin
          req_d = 1'b0;
          err_d = 1'b1;
          flush = 1'b1;
          state_d = FIN;
        end else if (srm2d_ack_i) begin
          req_d = 1'b0;
          pop = ~empty;
          dst_ptr_d = dst_ptr_q + AW'(DW/8);
          if (cnt == CW'(1)) state_d = rd_left_q != '0 ? RD : FIN;
        end
      FIN: begin
        done_d = 1'b1;
        irq_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: ;
    endcase
  end

  assign d2cpu_ack_o = ack_q;
  assign d2cpu_dat_o = cdat_q;
  assign d2srm_stb_o = req_q;
  assign d2srm_cyc_o = req_q;
  assign d2srm_we_o = req_q & (state_q == WR);
  assign d2srm_sel_o = {(DW/8){req_q}};
  assign d2srm_adr_o = !req_q ? '0 : state_q == WR ? dst_ptr_q : src_ptr_q;
  assign d2srm_dat_o = req_q && state_q == WR ? fifo_dat : '0;
  assign irq_o = irq_q;
endmodule

// File: tb/tb_wb_dma_copy.sv
// tb_wb_dma_copy: scoreboard bench; an SDRAM model serves reads with random data and
// checks every write against the queued expected address/data.
module tb_wb_dma_copy;
  logic clk = 1'b0, rst = 1'b0;
  logic cpu2d_stb_i = 1'b0, cpu2d_cyc_i = 1'b0, cpu2d_we_i = 1'b0;
  logic [31:0] cpu2d_adr_i = '0, cpu2d_dat_i = '0;
  logic d2cpu_ack_o, d2srm_stb_o, d2srm_cyc_o, d2srm_we_o, irq_o;
  logic [31:0] d2cpu_dat_o, d2srm_adr_o, d2srm_dat_o, srm2d_dat_i;
  logic [3:0] d2srm_sel_o;
  logic srm2d_ack_i, srm2d_err_i;
  logic [31:0] exp_rd_adr[$], exp_wr_adr[$], exp_wr_dat[$];
  bit ops[$];
  int exp_ph[$];
  int checks = 0, errors = 0;
  int max_dly = 0, err_at = -1, stall_at = -1, rd_tot = 0, wr_tot = 0, cyc_cnt = 0;
  bit stalled = 1'b0;

  always #5 clk = ~clk;

  wb_dma_copy dut (
    .clk(clk), .rst(rst), .cpu2d_stb_i(cpu2d_stb_i), .cpu2d_cyc_i(cpu2d_cyc_i), .cpu2d_we_i(cpu2d_we_i),
    .cpu2d_adr_i(cpu2d_adr_i), .cpu2d_dat_i(cpu2d_dat_i), .d2cpu_ack_o(d2cpu_ack_o), .d2cpu_dat_o(d2cpu_dat_o),
    .d2srm_stb_o(d2srm_stb_o), .d2srm_cyc_o(d2srm_cyc_o), .d2srm_we_o(d2srm_we_o), .d2srm_sel_o(d2srm_sel_o),
    .d2srm_adr_o(d2srm_adr_o), .d2srm_dat_o(d2srm_dat_o), .srm2d_ack_i(srm2d_ack_i), .srm2d_err_i(srm2d_err_i),
    .srm2d_dat_i(srm2d_dat_i), .irq_o(irq_o)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) if (d2srm_cyc_o) cyc_cnt++;

  initial begin
    logic [31:0] a, wd;
    logic w;
    int d;
    srm2d_ack_i = 1'b0;
    srm2d_err_i = 1'b0;
    srm2d_dat_i = '0;
    forever begin
      @(negedge clk);
      if (rst && d2srm_stb_o && d2srm_cyc_o) begin
        a = d2srm_adr_o;
        w = d2srm_we_o;
        wd = d2srm_dat_o;
        check("sel", d2srm_sel_o, 4'hf);
        if (w) begin
          check("wr_pending", exp_wr_adr.size() > 0 && exp_wr_dat.size() > 0, 1);
          if (exp_wr_adr.size() > 0) check("wr_adr", a, exp_wr_adr.pop_front());
          if (exp_wr_dat.size() > 0) check("wr_dat", wd, exp_wr_dat.pop_front());
        end else begin
          check("rd_pending", exp_rd_adr.size() > 0, 1);
          if (exp_rd_adr.size() > 0) check("rd_adr", a, exp_rd_adr.pop_front());
        end
        if (w && wr_tot == stall_at) begin
          stalled = 1'b1;
          wait (!rst);
          wait (rst);
          stalled = 1'b0;
        end else begin
          d = $urandom_range(max_dly, 0);
          repeat (d) begin
            @(negedge clk);
            check("stb_hold", {d2srm_stb_o, d2srm_cyc_o, d2srm_we_o, d2srm_adr_o, d2srm_dat_o}, {2'b11, w, a, wd});
          end
          if (!w && rd_tot == err_at) srm2d_err_i = 1'b1;
          else begin
            srm2d_ack_i = 1'b1;
            if (!w) begin
              srm2d_dat_i = $urandom;
              exp_wr_dat.push_back(srm2d_dat_i);
              rd_tot++;
            end else wr_tot++;
            ops.push_back(w);
          end
          @(negedge clk);
          srm2d_ack_i = 1'b0;
          srm2d_err_i = 1'b0;
          check("stb_gap", d2srm_stb_o, 0);
        end
      end
    end
  end

  task automatic cpu_acc(input logic we, input logic [31:0] adr, input logic [31:0] wd, output logic [31:0] rd);
    @(negedge clk);
    cpu2d_stb_i = 1'b1;
    cpu2d_cyc_i = 1'b1;
    cpu2d_we_i = we;
    cpu2d_adr_i = adr;
    cpu2d_dat_i = wd;
    @(negedge clk);
    check("cpu_ack", d2cpu_ack_o, 1);
    rd = d2cpu_dat_o;
    @(negedge clk);
    check("cpu_ack_once", d2cpu_ack_o, 0);
    cpu2d_stb_i = 1'b0;
    cpu2d_cyc_i = 1'b0;
    cpu2d_we_i = 1'b0;
  endtask

  task automatic cpu_wr(input logic [31:0] adr, input logic [31:0] wd);
    logic [31:0] r;
    cpu_acc(1'b1, adr, wd, r);
  endtask

  task automatic rd_reg(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] r;
    cpu_acc(1'b0, adr, '0, r);
    check(tag, r, exp);
  endtask

  task automatic setup_copy(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len);
    logic [31:0] s, t;
    ops.delete();
    s = src;
    t = dst;
    for (int i = 0; i < int'(len >> 2); i++) begin
      exp_rd_adr.push_back(s);
      exp_wr_adr.push_back(t);
      s = s + 32'd4;
      t = t + 32'd4;
    end
    cpu_wr(32'h0, src);
    cpu_wr(32'h4, dst);
    cpu_wr(32'h8, len);
    cpu_wr(32'hc, 32'h1);
  endtask

  task automatic wait_irq();
    int n = 0;
    while (!irq_o && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("irq_set", irq_o, 1);
  endtask

  task automatic finish_copy();
    int ph[$];
    int run = 0;
    wait_irq();
    check("rd_left", exp_rd_adr.size(), 0);
    check("wr_left", exp_wr_adr.size(), 0);
    check("dat_left", exp_wr_dat.size(), 0);
    foreach (ops[i])
      if (!ops[i]) run++;
      else if (run > 0) begin
        ph.push_back(run);
        run = 0;
      end
    if (run > 0) ph.push_back(run);
    check("phase_cnt", ph.size(), exp_ph.size());
    foreach (exp_ph[i]) check("phase_len", i < ph.size() ? ph[i] : -1, exp_ph[i]);
    rd_reg("stat_done", 32'hc, 32'h2);
    cpu_wr(32'hc, 32'h2);
    rd_reg("stat_clr", 32'hc, 32'h0);
    check("irq_clr", irq_o, 0);
  endtask

  initial begin
    int c0, n;
    repeat (3) @(negedge clk);
    check("rst_outs", {d2srm_stb_o, d2srm_cyc_o, d2srm_we_o, d2srm_sel_o, d2srm_adr_o, d2srm_dat_o,
                       d2cpu_ack_o, d2cpu_dat_o, irq_o}, 0);
    rst = 1'b1;
    rd_reg("stat_rst", 32'hc, 32'h0);
    rd_reg("src_rst", 32'h0, 32'h0);
    exp_ph = '{4, 4, 2};
    setup_copy(32'h100, 32'h200, 32'd40);
    finish_copy();
    rd_reg("src_rb", 32'h0, 32'h100);
    rd_reg("dst_rb", 32'h4, 32'h200);
    rd_reg("len_rb", 32'h8, 32'd40);
    c0 = cyc_cnt;
    cpu_wr(32'h8, 32'h0);
    cpu_wr(32'hc, 32'h1);
    rd_reg("stat_zero", 32'hc, 32'h2);
    check("irq_zero", irq_o, 1);
    check("no_cyc_zero", cyc_cnt - c0, 0);
    cpu_wr(32'hc, 32'h2);
    max_dly = 5;
    exp_ph = '{4, 4, 4, 4};
    setup_copy(32'h1000, 32'h2000, 32'd66);
    finish_copy();
    rd_reg("len_odd_rb", 32'h8, 32'd66);
    max_dly = 0;
    err_at = rd_tot + 2;
    for (int i = 0; i < 3; i++) exp_rd_adr.push_back(32'h1100 + 32'(4 * i));
    cpu_wr(32'h0, 32'h1100);
    cpu_wr(32'h4, 32'h2100);
    cpu_wr(32'h8, 32'd32);
    cpu_wr(32'hc, 32'h1);
    wait_irq();
    c0 = cyc_cnt;
    repeat (10) @(negedge clk);
    check("no_cyc_err", cyc_cnt - c0, 0);
    rd_reg("stat_err", 32'hc, 32'h6);
    check("err_rd_left", exp_rd_adr.size(), 0);
    check("err_rd_data", exp_wr_dat.size(), 2);
    exp_wr_dat.delete();
    err_at = -1;
    cpu_wr(32'hc, 32'h2);
    rd_reg("stat_err_clr", 32'hc, 32'h0);
    check("irq_err_clr", irq_o, 0);
    max_dly = 3;
    exp_ph = '{4, 4};
    setup_copy(32'h3000, 32'h4000, 32'd32);
    cpu_wr(32'h0, 32'hffff_fffc);
    cpu_wr(32'h8, 32'd8);
    cpu_wr(32'hc, 32'h1);
    rd_reg("src_busy", 32'h0, 32'h3000);
    rd_reg("len_busy", 32'h8, 32'd32);
    rd_reg("stat_busy", 32'hc, 32'h1);
    finish_copy();
    max_dly = 0;
    exp_ph = '{2};
    setup_copy(32'hffff_fffc, 32'h5000, 32'd8);
    finish_copy();
    stall_at = wr_tot + 1;
    setup_copy(32'h600, 32'h700, 32'd16);
    n = 0;
    while (!stalled && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("stall_seen", stalled, 1);
    rst = 1'b0;
    #1;
    check("rst_mid_outs", {d2srm_stb_o, d2srm_cyc_o, d2srm_we_o, d2srm_sel_o, d2srm_adr_o, d2srm_dat_o,
                           d2cpu_ack_o, d2cpu_dat_o, irq_o}, 0);
    exp_rd_adr.delete();
    exp_wr_adr.delete();
    exp_wr_dat.delete();
    stall_at = -1;
    @(negedge clk);
    rst = 1'b1;
    rd_reg("stat_after_rst", 32'hc, 32'h0);
    rd_reg("src_after_rst", 32'h0, 32'h0);
    rd_reg("len_after_rst", 32'h8, 32'h0);
    exp_ph = '{2};
    setup_copy(32'h800, 32'h900, 32'd8);
    finish_copy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
